// File: rtl/mult_add_pkg.sv
// Shared widths, constants and beat classification for the dual-product unit.
// Constants are built at a generous fixed width and sliced down by each user.
package mult_add_pkg;

  localparam int CONST_W = 128;

  typedef enum logic [1:0] {
    BK_NONE,
    BK_DIRECT,
    BK_ACC,
    BK_LAST
  } beat_kind_e;

  function automatic int prod_width(int data_width);
    return 2 * data_width;
  endfunction

  function automatic int sum_width(int data_width);
    return 2 * data_width + 1;
  endfunction

  function automatic int term_width(int data_width, int frac);
    return 2 * data_width + 1 - frac;
  endfunction

  function automatic int acc_width(int data_width, int frac, int acc_guard);
    return term_width(data_width, frac) + acc_guard;
  endfunction

  // Half an output LSB; zero when no fractional bits are dropped.
  function automatic logic signed [CONST_W-1:0] round_const(int frac);
    logic signed [CONST_W-1:0] r;
    r = '0;
    if (frac >= 1) begin
      r = CONST_W'(1) << (frac - 1);
    end
    return r;
  endfunction

  function automatic logic signed [CONST_W-1:0] sat_max(int out_w);
    return (CONST_W'(1) << (out_w - 1)) - CONST_W'(1);
  endfunction

  function automatic logic signed [CONST_W-1:0] sat_min(int out_w);
    return -(CONST_W'(1) << (out_w - 1));
  endfunction

  function automatic beat_kind_e beat_kind(logic vld, logic acc, logic last);
    beat_kind_e k;
    if (!vld) begin
      k = BK_NONE;
    end else if (!acc) begin
      k = BK_DIRECT;
    end else if (last) begin
      k = BK_LAST;
    end else begin
      k = BK_ACC;
    end
    return k;
  endfunction

endpackage

// File: rtl/mult_add_pipe_if.sv
// Valid/ready operand and result channel of mult_add_pipe.
// The slave modport is the unit's view, the master modport the surrounding datapath's.
interface mult_add_pipe_if #(
  parameter int DATA_WIDTH = 20
);

  logic                         i_valid;
  logic                         o_ready;
  logic signed [DATA_WIDTH-1:0] i_a1;
  logic signed [DATA_WIDTH-1:0] i_a2;
  logic signed [DATA_WIDTH-1:0] i_b1;
  logic signed [DATA_WIDTH-1:0] i_b2;
  logic                         i_sub;
  logic                         i_acc;
  logic                         i_last;

  logic                         o_valid;
  logic                         i_ready;
  logic signed [DATA_WIDTH-1:0] o_data;
  logic                         o_sat;

  modport slave (
    input  i_valid,
    input  i_a1,
    input  i_a2,
    input  i_b1,
    input  i_b2,
    input  i_sub,
    input  i_acc,
    input  i_last,
    input  i_ready,
    output o_ready,
    output o_valid,
    output o_data,
    output o_sat
  );

  modport master (
    output i_valid,
    output i_a1,
    output i_a2,
    output i_b1,
    output i_b2,
    output i_sub,
    output i_acc,
    output i_last,
    output i_ready,
    input  o_ready,
    input  o_valid,
    input  o_data,
    input  o_sat
  );

endinterface

// File: rtl/fx_round_sat.sv
// Combinational round-half-up (drop SHIFT LSBs) followed by an optional clamp to OUT_W.
// Expects IN_W - SHIFT >= OUT_W; with SAT_EN=0 the rounded value is simply resized.
module fx_round_sat
  import mult_add_pkg::*;
#(
  parameter int IN_W   = 41,
  parameter int SHIFT  = 16,
  parameter int OUT_W  = 25,
  parameter bit SAT_EN = 1'b0
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout,
  output logic                    sat
);

  localparam int RW = IN_W - SHIFT;
  localparam logic signed [CONST_W-1:0] RND_F = round_const(SHIFT);
  localparam logic signed [IN_W-1:0]    RND   = RND_F[IN_W-1:0];

  logic signed [RW-1:0] rnd;

  // Headroom: the caller's sum never reaches the top bit, so adding RND cannot wrap.
  assign rnd = RW'((din + RND) >>> SHIFT);

  if (SAT_EN) begin : g_sat
    localparam logic signed [CONST_W-1:0] MAX_F = sat_max(OUT_W);
    localparam logic signed [CONST_W-1:0] MIN_F = sat_min(OUT_W);
    localparam logic signed [RW-1:0]      MAX_R = MAX_F[RW-1:0];
    localparam logic signed [RW-1:0]      MIN_R = MIN_F[RW-1:0];

    always_comb begin
      dout = OUT_W'(rnd);
      sat  = 1'b0;
      if (rnd > MAX_R) begin
        dout = OUT_W'(MAX_R);
        sat  = 1'b1;
      end else if (rnd < MIN_R) begin
        dout = OUT_W'(MIN_R);
        sat  = 1'b1;
      end
    end
  end else begin : g_wrap
    assign dout = OUT_W'(rnd);
    assign sat  = 1'b0;
  end

endmodule

// File: rtl/mult_add_pipe.sv
// Three-stage a1*a2 +/- b1*b2 unit with round-half-up, saturation and packet accumulate.
// One global enable stalls every stage while a result is waiting on downstream.
module mult_add_pipe
  import mult_add_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int FRAC       = 16,
  parameter int ACC_GUARD  = 4
) (
  input  logic           i_clk,
  input  logic           i_rst,
  mult_add_pipe_if.slave bus
);

  localparam int PW = prod_width(DATA_WIDTH);
  localparam int SW = sum_width(DATA_WIDTH);
  localparam int TW = term_width(DATA_WIDTH, FRAC);
  localparam int AW = acc_width(DATA_WIDTH, FRAC, ACC_GUARD);

  logic en;

  // S1: products and beat tags
  logic signed [PW-1:0] s1_pa;
  logic signed [PW-1:0] s1_pb;
  logic                 s1_vld;
  logic                 s1_sub;
  logic                 s1_acc;
  logic                 s1_last;

  // S2: rounded term
  logic signed [SW-1:0] pa_x;
  logic signed [SW-1:0] pb_x;
  logic signed [SW-1:0] sum_c;
  logic signed [TW-1:0] t_c;
  logic                 t_sat_c;
  logic signed [TW-1:0] s2_t;
  logic                 s2_tsat;
  logic                 s2_vld;
  logic                 s2_acc;
  logic                 s2_last;

  // S3: accumulator and output
  beat_kind_e                   kind;
  logic signed [AW-1:0]         t_x;
  logic signed [AW-1:0]         acc_sum;
  logic signed [AW-1:0]         sat_in;
  logic signed [DATA_WIDTH-1:0] sat_dout;
  logic                         sat_flag;
  logic signed [AW-1:0]         acc_q;
  logic                         o_valid_q;
  logic signed [DATA_WIDTH-1:0] o_data_q;
  logic                         o_sat_q;

  assign en          = !o_valid_q || bus.i_ready;
  assign bus.o_ready = en;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_sat   = o_sat_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_pa   <= '0;
      s1_pb   <= '0;
      s1_vld  <= 1'b0;
      s1_sub  <= 1'b0;
      s1_acc  <= 1'b0;
      s1_last <= 1'b0;
    end else if (en) begin
      s1_pa   <= PW'(bus.i_a1) * PW'(bus.i_a2);
      s1_pb   <= PW'(bus.i_b1) * PW'(bus.i_b2);
      s1_vld  <= bus.i_valid;
      s1_sub  <= bus.i_sub;
      s1_acc  <= bus.i_acc;
      s1_last <= bus.i_last;
    end
  end

  // Sign-extend before combining so the difference is an exact two's-complement negate.
  assign pa_x  = SW'(s1_pa);
  assign pb_x  = SW'(s1_pb);
  assign sum_c = s1_sub ? (pa_x - pb_x) : (pa_x + pb_x);

  fx_round_sat #(
    .IN_W   (SW),
    .SHIFT  (FRAC),
    .OUT_W  (TW),
    .SAT_EN (1'b0)
  ) u_term_round (
    .din  (sum_c),
    .dout (t_c),
    .sat  (t_sat_c)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s2_t    <= '0;
      s2_tsat <= 1'b0;
      s2_vld  <= 1'b0;
      s2_acc  <= 1'b0;
      s2_last <= 1'b0;
    end else if (en) begin
      s2_t    <= t_c;
      s2_tsat <= t_sat_c;
      s2_vld  <= s1_vld;
      s2_acc  <= s1_acc;
      s2_last <= s1_last;
    end
  end

  assign kind    = beat_kind(s2_vld, s2_acc, s2_last);
  assign t_x     = AW'(s2_t);
  assign acc_sum = acc_q + t_x;
  assign sat_in  = (kind == BK_DIRECT) ? t_x : acc_sum;

  fx_round_sat #(
    .IN_W   (AW),
    .SHIFT  (0),
    .OUT_W  (DATA_WIDTH),
    .SAT_EN (1'b1)
  ) u_out_sat (
    .din  (sat_in),
    .dout (sat_dout),
    .sat  (sat_flag)
  );

  // Direct beats leave acc_q alone so an open packet survives them.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_sat_q   <= 1'b0;
    end else if (en) begin
      o_valid_q <= 1'b0;
      case (kind)
        BK_DIRECT: begin
          o_valid_q <= 1'b1;
          o_data_q  <= sat_dout;
          o_sat_q   <= sat_flag | s2_tsat;
        end
        BK_ACC: begin
          acc_q <= acc_sum;
        end
        BK_LAST: begin
          o_valid_q <= 1'b1;
          o_data_q  <= sat_dout;
          o_sat_q   <= sat_flag | s2_tsat;
          acc_q     <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
